// File: rtl/combo_lock_pkg.sv
// Shared constants and state encoding for the combination lock.
// The PROG state exists only when COMBO_LOCK_PROGRAM_EN is defined.
package combo_lock_pkg;

  // Defaults shared with the digit selector and the display top level.
  localparam int              DEF_DIGIT_W    = 4;
  localparam int              DEF_NUM_DIGITS = 4;
  localparam logic [15:0]     DEF_CODE       = 16'h1234;

  // Lock state encoding.
  typedef enum logic [2:0] {
    ENTRY   = 3'd0,
    CHECK   = 3'd1,
    OPEN    = 3'd2,
`ifdef COMBO_LOCK_PROGRAM_EN
    LOCKOUT = 3'd3,
    PROG    = 3'd4
`else
    LOCKOUT = 3'd3
`endif
  } state_t;

  // Width of a counter that must hold values 0..n-1, never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/combo_lock_fsm_if.sv
// Digit/command bus between the digit selector, the lock FSM and the display.
// master: the selector/display side; slave: the lock.
interface combo_lock_fsm_if
  import combo_lock_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int DIGIT_W    = DEF_DIGIT_W
);

  localparam int CODE_W = NUM_DIGITS * DIGIT_W;
  localparam int IDX_W  = $clog2(NUM_DIGITS);

  logic [DIGIT_W-1:0] digit_in;
  logic               enter;
  logic               clear;
  logic               prog;
  logic [CODE_W-1:0]  entered;
  logic [IDX_W-1:0]   digit_idx;
  logic               unlocked;
  logic               err;
  logic               alarm;

  modport master (
    output digit_in, enter, clear, prog,
    input  entered, digit_idx, unlocked, err, alarm
  );

  modport slave (
    input  digit_in, enter, clear, prog,
    output entered, digit_idx, unlocked, err, alarm
  );

endinterface

// File: rtl/lockout_timer.sv
// Loadable down-counter that times the alarm lockout.
// load sets the count to LOCKOUT_CYCLES-1; it then counts down to 0 and holds.
// done is high whenever the count is 0.
module lockout_timer
  import combo_lock_pkg::*;
#(
  parameter int LOCKOUT_CYCLES = 100_000_000
)(
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int                 TIMER_W  = cnt_width(LOCKOUT_CYCLES);
  localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(LOCKOUT_CYCLES - 1);

  logic [TIMER_W-1:0] count;

  // Load, then decrement to zero and stay there.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/combo_lock_fsm.sv
// Code-checking stage of the combination lock.
// Captures a digit per enter pulse, checks a full entry against the stored
// code, and drives unlocked / err / alarm (all registered).
// Optional feature: define COMBO_LOCK_PROGRAM_EN to allow reprogramming the
// code from the OPEN state; otherwise the code is the constant CODE.
module combo_lock_fsm
  import combo_lock_pkg::*;
#(
  parameter int                            NUM_DIGITS     = DEF_NUM_DIGITS,
  parameter int                            DIGIT_W        = DEF_DIGIT_W,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] CODE           = DEF_CODE,
  parameter int                            MAX_TRIES      = 3,
  parameter int                            LOCKOUT_CYCLES = 100_000_000
)(
  input logic             clk,
  input logic             rst,
  combo_lock_fsm_if.slave bus
);

  localparam int                 CODE_W   = NUM_DIGITS * DIGIT_W;
  localparam int                 IDX_W    = $clog2(NUM_DIGITS);
  localparam int                 FAIL_W   = cnt_width(MAX_TRIES + 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  state_t              state;
  logic [CODE_W-1:0]   entered;
  logic [IDX_W-1:0]    digit_idx;
  logic [FAIL_W-1:0]   fail_cnt;
  logic                unlocked;
  logic                err;
  logic                alarm;

  logic [CODE_W-1:0]   entered_shift;
  logic [CODE_W-1:0]   stored_code;
  logic                code_match;
  logic                last_try;
  logic                timer_load;
  logic                timer_done;

  // Newest digit enters at the LS end; the first digit ends up in the MS slot.
  assign entered_shift = {entered[CODE_W-DIGIT_W-1:0], bus.digit_in};
  assign code_match    = (entered == stored_code);
  // This failure would be the MAX_TRIES-th in a row.
  assign last_try      = (int'(fail_cnt) + 1 >= MAX_TRIES);
  assign timer_load    = (state == CHECK) && !code_match && last_try;

`ifdef COMBO_LOCK_PROGRAM_EN
  logic [CODE_W-1:0] code_q;

  // Programmable code register; reverts to CODE on every reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q <= CODE;
    end else if (state == PROG && !bus.clear && bus.enter && digit_idx == LAST_IDX) begin
      code_q <= entered_shift;
    end
  end

  assign stored_code = code_q;
`else
  assign stored_code = CODE;
`endif

  lockout_timer #(
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) u_lockout_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .done (timer_done)
  );

  // Lock state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ENTRY;
      entered   <= '0;
      digit_idx <= '0;
      fail_cnt  <= '0;
      unlocked  <= 1'b0;
      err       <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        ENTRY: begin
          // clear beats a simultaneous enter.
          if (bus.clear) begin
            entered   <= '0;
            digit_idx <= '0;
          end else if (bus.enter) begin
            entered <= entered_shift;
            if (digit_idx == LAST_IDX) begin
              digit_idx <= '0;
              state     <= CHECK;
            end else begin
              digit_idx <= digit_idx + 1'b1;
            end
          end
        end

        // Single-cycle compare; enter/clear arriving here are dropped.
        CHECK: begin
          if (code_match) begin
            state    <= OPEN;
            fail_cnt <= '0;
            unlocked <= 1'b1;
          end else if (last_try) begin
            state   <= LOCKOUT;
            alarm   <= 1'b1;
            entered <= '0;
          end else begin
            state    <= ENTRY;
            fail_cnt <= fail_cnt + 1'b1;
            err      <= 1'b1;
            entered  <= '0;
          end
        end

        // Any enter or clear relocks; prog (when built in) starts programming.
        OPEN: begin
          if (bus.enter || bus.clear) begin
            state    <= ENTRY;
            unlocked <= 1'b0;
            entered  <= '0;
            digit_idx <= '0;
          end
`ifdef COMBO_LOCK_PROGRAM_EN
          else if (bus.prog) begin
            state     <= PROG;
            entered   <= '0;
            digit_idx <= '0;
          end
`endif
        end

        // All inputs ignored until the timer expires.
        LOCKOUT: begin
          if (timer_done) begin
            state    <= ENTRY;
            alarm    <= 1'b0;
            fail_cnt <= '0;
          end
        end

`ifdef COMBO_LOCK_PROGRAM_EN
        // Capture a new code; the final digit commits it and relocks.
        PROG: begin
          if (bus.clear) begin
            state     <= OPEN;
            entered   <= '0;
            digit_idx <= '0;
          end else if (bus.enter) begin
            if (digit_idx == LAST_IDX) begin
              state     <= ENTRY;
              unlocked  <= 1'b0;
              entered   <= '0;
              digit_idx <= '0;
            end else begin
              entered   <= entered_shift;
              digit_idx <= digit_idx + 1'b1;
            end
          end
        end
`endif

        default: begin
          state    <= ENTRY;
          unlocked <= 1'b0;
          alarm    <= 1'b0;
          entered  <= '0;
          digit_idx <= '0;
        end
      endcase
    end
  end

  assign bus.entered   = entered;
  assign bus.digit_idx = digit_idx;
  assign bus.unlocked  = unlocked;
  assign bus.err       = err;
  assign bus.alarm     = alarm;

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Directed testbench for combo_lock_fsm (NUM_DIGITS=4, CODE=16'h1234,
// MAX_TRIES=3, LOCKOUT_CYCLES=8). Programming tests run when
// COMBO_LOCK_PROGRAM_EN is defined; otherwise prog must be ignored.
module tb_combo_lock_fsm;

  logic clk = 1'b0;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  combo_lock_fsm_if #(.NUM_DIGITS(4), .DIGIT_W(4)) bus ();

  combo_lock_fsm #(
    .NUM_DIGITS     (4),
    .DIGIT_W        (4),
    .CODE           (16'h1234),
    .MAX_TRIES      (3),
    .LOCKOUT_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // One clock edge; outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_digit(input logic [3:0] d);
    bus.digit_in = d;
    bus.enter    = 1'b1;
    step();
    bus.enter    = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) enter_digit(c[i*4 +: 4]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.digit_in = '0; bus.enter = 0; bus.clear = 0; bus.prog = 0;
    rst = 1'b1;
    step(); step();
    vectors++; if (bus.entered !== 16'h0) begin miscompares++; $display("FAIL rst_entered: got %h exp %h", bus.entered, 16'h0); end
    vectors++; if (bus.digit_idx !== 2'd0) begin miscompares++; $display("FAIL rst_idx: got %0d exp 0", bus.digit_idx); end
    vectors++; if ({bus.unlocked, bus.err, bus.alarm} !== 3'b000) begin miscompares++; $display("FAIL rst_flags: got %b exp 000", {bus.unlocked, bus.err, bus.alarm}); end
    rst = 1'b0;
  endtask

  task automatic test_unlock();
    enter_digit(4'h1); enter_digit(4'h2);
    vectors++; if (bus.digit_idx !== 2'd2) begin miscompares++; $display("FAIL t1_idx2: got %0d exp 2", bus.digit_idx); end
    vectors++; if (bus.entered !== 16'h0012) begin miscompares++; $display("FAIL t1_partial: got %h exp 0012", bus.entered); end
    enter_digit(4'h3); enter_digit(4'h4);
    vectors++; if (bus.entered !== 16'h1234) begin miscompares++; $display("FAIL t1_entered: got %h exp 1234", bus.entered); end
    vectors++; if (bus.digit_idx !== 2'd0) begin miscompares++; $display("FAIL t1_idx_wrap: got %0d exp 0", bus.digit_idx); end
    vectors++; if (bus.unlocked !== 1'b0) begin miscompares++; $display("FAIL t1_unlock_early: got %b exp 0", bus.unlocked); end
    step();
    vectors++; if (bus.unlocked !== 1'b1) begin miscompares++; $display("FAIL t1_unlocked: got %b exp 1", bus.unlocked); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL t1_err: got %b exp 0", bus.err); end
    vectors++; if (bus.entered !== 16'h1234) begin miscompares++; $display("FAIL t1_open_entered: got %h exp 1234", bus.entered); end
`ifndef COMBO_LOCK_PROGRAM_EN
    bus.prog = 1'b1; step(); bus.prog = 1'b0;
    vectors++; if (bus.unlocked !== 1'b1) begin miscompares++; $display("FAIL t1_prog_ignored: got %b exp 1", bus.unlocked); end
    vectors++; if (bus.entered !== 16'h1234) begin miscompares++; $display("FAIL t1_prog_entered: got %h exp 1234", bus.entered); end
`endif
    bus.clear = 1'b1; step(); bus.clear = 1'b0;
    vectors++; if (bus.unlocked !== 1'b0) begin miscompares++; $display("FAIL t1_relock: got %b exp 0", bus.unlocked); end
    vectors++; if (bus.entered !== 16'h0) begin miscompares++; $display("FAIL t1_relock_entered: got %h exp 0", bus.entered); end
  endtask

  task automatic test_mismatch();
    enter_code(16'h1235);
    vectors++; if (bus.entered !== 16'h1235) begin miscompares++; $display("FAIL t2_entered: got %h exp 1235", bus.entered); end
    step();
    vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL t2_err: got %b exp 1", bus.err); end
    vectors++; if (bus.unlocked !== 1'b0) begin miscompares++; $display("FAIL t2_unlocked: got %b exp 0", bus.unlocked); end
    vectors++; if (bus.entered !== 16'h0) begin miscompares++; $display("FAIL t2_cleared: got %h exp 0", bus.entered); end
    vectors++; if (bus.digit_idx !== 2'd0) begin miscompares++; $display("FAIL t2_idx: got %0d exp 0", bus.digit_idx); end
    vectors++; if (bus.alarm !== 1'b0) begin miscompares++; $display("FAIL t2_alarm: got %b exp 0", bus.alarm); end
    step();
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL t2_err_width: got %b exp 0", bus.err); end
  endtask

  task automatic test_lockout();
    int alarm_cycles;
    do_reset();
    enter_code(16'h5555); step();
    vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL t3_err1: got %b exp 1", bus.err); end
    enter_code(16'h6666); step();
    vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL t3_err2: got %b exp 1", bus.err); end
    enter_code(16'h7777); step();
    vectors++; if (bus.alarm !== 1'b1) begin miscompares++; $display("FAIL t3_alarm: got %b exp 1", bus.alarm); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL t3_no_err: got %b exp 0", bus.err); end
    vectors++; if (bus.entered !== 16'h0) begin miscompares++; $display("FAIL t3_entered: got %h exp 0", bus.entered); end
    alarm_cycles = 1;
    for (int i = 0; i < 20; i++) begin
      bus.digit_in = 4'h1;
      bus.enter    = 1'b1;
      bus.clear    = i[0];
      step();
      vectors++; if (bus.digit_idx !== 2'd0) begin miscompares++; $display("FAIL t3_idx_locked: got %0d exp 0", bus.digit_idx); end
      if (bus.alarm !== 1'b1) break;
      alarm_cycles++;
    end
    bus.enter = 1'b0; bus.clear = 1'b0;
    vectors++; if (alarm_cycles !== 8) begin miscompares++; $display("FAIL t3_alarm_len: got %0d exp 8", alarm_cycles); end
    vectors++; if (bus.entered !== 16'h0) begin miscompares++; $display("FAIL t3_after_entered: got %h exp 0", bus.entered); end
    // Failure counter restarts: a single wrong code only warns.
    enter_code(16'h4321); step();
    vectors++; if ({bus.err, bus.alarm} !== 2'b10) begin miscompares++; $display("FAIL t3_cnt_cleared: got %b exp 10", {bus.err, bus.alarm}); end
    enter_code(16'h1234); step();
    vectors++; if (bus.unlocked !== 1'b1) begin miscompares++; $display("FAIL t3_unlock: got %b exp 1", bus.unlocked); end
  endtask

  task automatic test_clear_wins();
    do_reset();
    enter_digit(4'h1); enter_digit(4'h2);
    bus.digit_in = 4'h3; bus.enter = 1'b1; bus.clear = 1'b1;
    step();
    bus.enter = 1'b0; bus.clear = 1'b0;
    vectors++; if (bus.digit_idx !== 2'd0) begin miscompares++; $display("FAIL t4_idx: got %0d exp 0", bus.digit_idx); end
    vectors++; if (bus.entered !== 16'h0) begin miscompares++; $display("FAIL t4_entered: got %h exp 0", bus.entered); end
    enter_digit(4'h3); enter_digit(4'h4); step(); step();
    vectors++; if (bus.unlocked !== 1'b0) begin miscompares++; $display("FAIL t4_partial_open: got %b exp 0", bus.unlocked); end
    vectors++; if (bus.entered !== 16'h0034) begin miscompares++; $display("FAIL t4_partial: got %h exp 0034", bus.entered); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    enter_code(16'h1234);
    // This enter lands in CHECK and must be dropped.
    enter_digit(4'h9);
    vectors++; if (bus.unlocked !== 1'b1) begin miscompares++; $display("FAIL t7_unlocked: got %b exp 1", bus.unlocked); end
    vectors++; if (bus.entered !== 16'h1234) begin miscompares++; $display("FAIL t7_entered: got %h exp 1234", bus.entered); end
    vectors++; if (bus.digit_idx !== 2'd0) begin miscompares++; $display("FAIL t7_idx: got %0d exp 0", bus.digit_idx); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enter_code(16'h1111); step();
    enter_code(16'h2222); step();
    enter_code(16'h3333); step(); step(); step();
    vectors++; if (bus.alarm !== 1'b1) begin miscompares++; $display("FAIL t5_in_lockout: got %b exp 1", bus.alarm); end
    rst = 1'b1; step(); rst = 1'b0;
    vectors++; if ({bus.unlocked, bus.err, bus.alarm} !== 3'b000) begin miscompares++; $display("FAIL t5_lock_rst_flags: got %b exp 000", {bus.unlocked, bus.err, bus.alarm}); end
    vectors++; if (bus.entered !== 16'h0) begin miscompares++; $display("FAIL t5_lock_rst_entered: got %h exp 0", bus.entered); end
    enter_code(16'h1111); step();
    vectors++; if ({bus.err, bus.alarm} !== 2'b10) begin miscompares++; $display("FAIL t5_fail_cnt_rst: got %b exp 10", {bus.err, bus.alarm}); end
    enter_digit(4'h1); enter_digit(4'h2);
    vectors++; if (bus.digit_idx !== 2'd2) begin miscompares++; $display("FAIL t5_mid_idx: got %0d exp 2", bus.digit_idx); end
    rst = 1'b1; step(); rst = 1'b0;
    vectors++; if (bus.digit_idx !== 2'd0) begin miscompares++; $display("FAIL t5_entry_rst_idx: got %0d exp 0", bus.digit_idx); end
    vectors++; if (bus.entered !== 16'h0) begin miscompares++; $display("FAIL t5_entry_rst_entered: got %h exp 0", bus.entered); end
    enter_code(16'h1234); step();
    rst = 1'b1; step(); rst = 1'b0;
    vectors++; if (bus.unlocked !== 1'b0) begin miscompares++; $display("FAIL t5_open_rst: got %b exp 0", bus.unlocked); end
  endtask

`ifdef COMBO_LOCK_PROGRAM_EN
  task automatic test_prog();
    do_reset();
    enter_code(16'h1234); step();
    bus.prog = 1'b1; step(); bus.prog = 1'b0;
    vectors++; if (bus.unlocked !== 1'b1) begin miscompares++; $display("FAIL t6_prog_unlocked: got %b exp 1", bus.unlocked); end
    vectors++; if (bus.entered !== 16'h0) begin miscompares++; $display("FAIL t6_prog_entered: got %h exp 0", bus.entered); end
    enter_code(16'h9876);
    vectors++; if (bus.unlocked !== 1'b0) begin miscompares++; $display("FAIL t6_relocked: got %b exp 0", bus.unlocked); end
    enter_code(16'h1234); step();
    vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL t6_old_code: got %b exp 1", bus.err); end
    enter_code(16'h9876); step();
    vectors++; if (bus.unlocked !== 1'b1) begin miscompares++; $display("FAIL t6_new_code: got %b exp 1", bus.unlocked); end
    bus.prog = 1'b1; step(); bus.prog = 1'b0;
    enter_digit(4'h5);
    bus.clear = 1'b1; step(); bus.clear = 1'b0;
    vectors++; if (bus.unlocked !== 1'b1) begin miscompares++; $display("FAIL t6_abort_open: got %b exp 1", bus.unlocked); end
    bus.clear = 1'b1; step(); bus.clear = 1'b0;
    enter_code(16'h9876); step();
    vectors++; if (bus.unlocked !== 1'b1) begin miscompares++; $display("FAIL t6_code_kept: got %b exp 1", bus.unlocked); end
    do_reset();
    enter_code(16'h1234); step();
    vectors++; if (bus.unlocked !== 1'b1) begin miscompares++; $display("FAIL t6_code_reverted: got %b exp 1", bus.unlocked); end
  endtask
`endif

  initial begin
    test_reset();
    test_unlock();
    test_mismatch();
    test_lockout();
    test_clear_wins();
    test_back_to_back();
    test_reset_mid();
`ifdef COMBO_LOCK_PROGRAM_EN
    test_prog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
